dct_stage_pipe: RTL

Parametrised, elastic pipeline register placed between butterfly stages of the JPEG DCT datapath. It carries a vector of LANES coefficients of W bits each and replaces the fixed two-lane, reset-gated pass-through stage with three additions: a valid/ready handshake, a two-entry skid buffer that sustains full throughput under backpressure, and a row counter that tags the last row of each 8×8 block. Even/odd lane reordering for the next butterfly is compiled in optionally.

---
 rtl/dct_stage_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dct_stage_pipe.sv
// dct_stage_pipe: elastic pipeline register between DCT butterfly stages.
// Carries LANES coefficients of W bits through a two-entry skid buffer
// (main + skid) with a valid/ready handshake, and tags every vector with
// its row number inside an ROWS-row block plus a last-row flag.
// Optional build macro: DCT_STAGE_REORDER_EN -- when defined, entering
// vectors are permuted even lanes first, then odd lanes.
module dct_stage_pipe #(
  parameter int W     = 8,
  parameter int LANES = 8,
  parameter int ROWS  = 8,
  localparam int CW   = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               out_last,
  output logic [CW-1:0]      row_idx
);

  // Occupancy states; encoding mirrors {main valid, skid valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  localparam logic [CW-1:0] ROW_MAX = CW'(ROWS - 1);

  state_t               state_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic [LANES*W-1:0]   main_data_reg;
  logic                 main_last_reg;
  logic [CW-1:0]        main_row_reg;
  logic [LANES*W-1:0]   skid_data_reg;
  logic                 skid_last_reg;
  logic [CW-1:0]        skid_row_reg;
  logic [CW-1:0]        rc_reg;

  logic                 in_fire;
  logic                 out_fire;
  logic [LANES*W-1:0]   entry_data;
  logic                 entry_last;

  assign in_fire    = in_valid & in_ready_reg;
  assign out_fire   = out_valid_reg & out_ready;
  assign entry_last = (rc_reg == ROW_MAX);

`ifdef DCT_STAGE_REORDER_EN
  // Even lanes go to the lower half, odd lanes to the upper half.
  for (genvar gi = 0; gi < LANES / 2; gi++) begin : g_perm
    assign entry_data[gi*W +: W]             = in_data[(2*gi)*W +: W];
    assign entry_data[(LANES/2 + gi)*W +: W] = in_data[(2*gi + 1)*W +: W];
  end
`else
  // Straight pass-through, lane k stays lane k.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_pass
    assign entry_data[gi*W +: W] = in_data[gi*W +: W];
  end
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = main_data_reg;
  assign out_last  = main_last_reg;
  assign row_idx   = main_row_reg;

  // Skid-buffer occupancy FSM, row counter and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      main_data_reg <= '0;
      main_last_reg <= 1'b0;
      main_row_reg  <= '0;
      skid_data_reg <= '0;
      skid_last_reg <= 1'b0;
      skid_row_reg  <= '0;
      rc_reg        <= '0;
    end else begin
      if (in_fire) begin
        rc_reg <= (rc_reg == ROW_MAX) ? '0 : rc_reg + CW'(1);
      end
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_data_reg <= entry_data;
            main_last_reg <= entry_last;
            main_row_reg  <= rc_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            // Consumer drains main while the producer refills it.
            main_data_reg <= entry_data;
            main_last_reg <= entry_last;
            main_row_reg  <= rc_reg;
          end else if (in_fire) begin
            skid_data_reg <= entry_data;
            skid_last_reg <= entry_last;
            skid_row_reg  <= rc_reg;
            in_ready_reg  <= 1'b0;
            state_reg     <= FULL;
          end else if (out_fire) begin
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            main_data_reg <= skid_data_reg;
            main_last_reg <= skid_last_reg;
            main_row_reg  <= skid_row_reg;
            in_ready_reg  <= 1'b1;
            state_reg     <= ONE;
          end
        end
        default: begin
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          state_reg     <= EMPTY;
        end
      endcase
    end
  end

endmodule
